// File: rtl/decoder_pkg.sv
// Shared types and helpers for the 3-to-8 streaming decoder.
// Holds code/word widths, the control FSM state enum and the decode function.
// No ports; imported by decoder_3x8_stream and onehot_fifo.
package decoder_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // One-hot decode of a binary code; a disabled decoder yields an all-zero word.
    function automatic logic [OUT_W-1:0] decode(input logic [CODE_W-1:0] code,
                                                input logic              en);
        return en ? (OUT_W'(1) << code) : '0;
    endfunction

endpackage

// File: rtl/onehot_fifo.sv
// Small synchronous FIFO buffering decoded words between decoder and consumer.
// Ports: push_i/push_dat_i write the tail, pop_i advances the head, pop_dat_o shows
//        the head word (zero when empty), full_o/empty_o/count_o report occupancy.
module onehot_fifo
    import decoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = OUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    // Guard locally so a careless caller can never overrun or underrun.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    // Empty buffer presents a clean zero word rather than stale storage.
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/decoder_3x8_stream.sv
// Streaming 3-to-8 decoder with a DEPTH-word output buffer and a walking-one self-test sweep.
// Ports: in_valid/in_ready/in_code/in_en input stream, scan_start sweep request,
//        out_valid/out_ready/out_data output stream, busy during sweep, dec_count of output handshakes.
module decoder_3x8_stream
    import decoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_en,
    input  logic              scan_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  dec_count
);

    localparam int FCNT_W = $clog2(DEPTH) + 1;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]    dec_cnt_q, dec_cnt_d;

    logic                fifo_full, fifo_empty;
    logic [FCNT_W-1:0]   fifo_cnt;
    logic                in_push, scan_push, push, pop;
    logic [OUT_W-1:0]    push_dat;

    // scan_start outranks a same-cycle input, so it gates in_ready directly.
    assign in_ready  = (state_q == IDLE) && !fifo_full && !scan_start;
    assign in_push   = in_valid && in_ready;
    // Sweep advances only when a slot is free; it stalls rather than drops.
    assign scan_push = (state_q == SCAN) && (fifo_cnt < FCNT_W'(DEPTH));
    assign push      = in_push || scan_push;
    assign push_dat  = scan_push ? decode(idx_q, 1'b1) : decode(in_code, in_en);

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign dec_count = dec_cnt_q;

    onehot_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (out_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dec_cnt_q <= dec_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dec_cnt_d = dec_cnt_q;
        if (pop) dec_cnt_d = dec_cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: if (scan_start) state_d = SCAN;
            SCAN: begin
                if (scan_push) begin
                    // Index 7 wraps to 0 by overflow, ready for the next sweep.
                    idx_d = idx_q + CODE_W'(1);
                    if (idx_q == '1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == SCAN);
    end

endmodule

// File: tb/tb_decoder_3x8_stream.sv
module tb_decoder_3x8_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_code = 3'd0;
    logic       in_en = 1'b0;
    logic       scan_start = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;
    logic [3:0] dec_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] sb[$];

    // Hand-computed one-hot words for codes 0..7.
    logic [7:0] onehot_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    always #5 clk = ~clk;

    decoder_3x8_stream #(.DEPTH(2), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .scan_start (scan_start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .dec_count  (dec_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) check("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
                    else check("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
                end else if (!out_valid) begin
                    check("empty_zero", {24'd0, out_data}, 32'h0);
                end
            end
        end
    end

    // Drive one input word; the expected word is queued at the accepting edge.
    task automatic send(input logic [2:0] c, input logic e, input logic [7:0] exp_w);
        bit ok = 1'b0;
        in_valid = 1'b1; in_code = c; in_en = e;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp_w);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        @(posedge clk); #1;
        if (!ok) check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        int bc;
        // Reset state, observed while reset is held.
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'h0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_dec_count", {28'd0, dec_count}, 32'd0);
        #10 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Codes 0..7, consumer always ready; each word visible right after acceptance.
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            send(3'(c), 1'b1, onehot_tbl[c]);
            check("latency_valid", {31'd0, out_valid}, 32'd1);
        end
        wait_drain();
        check("count_after_8", {28'd0, dec_count}, 32'd8);

        // Disabled decoder gives a valid zero word.
        send(3'b101, 1'b0, 8'h00);
        check("dis_valid", {31'd0, out_valid}, 32'd1);
        check("dis_data",  {24'd0, out_data},  32'h0);
        wait_drain();
        check("count_after_9", {28'd0, dec_count}, 32'd9);

        // Backpressure: fill DEPTH=2, third word stalls until a pop frees a slot.
        out_ready = 1'b0;
        send(3'd1, 1'b1, 8'h02);
        send(3'd2, 1'b1, 8'h04);
        in_valid = 1'b1; in_code = 3'd3; in_en = 1'b1;
        @(negedge clk);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("no_same_cycle_refill", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("refill_in_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) sb.push_back(8'h08);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();
        check("count_after_12", {28'd0, dec_count}, 32'd12);

        // Sweep: scan_start wins over a same-cycle input.
        scan_start = 1'b1; in_valid = 1'b1; in_code = 3'd6; in_en = 1'b1;
        @(negedge clk);
        check("scan_blocks_input", {31'd0, in_ready}, 32'd0);
        for (int c = 0; c < 8; c++) sb.push_back(onehot_tbl[c]);
        @(posedge clk); #1;
        scan_start = 1'b0; in_valid = 1'b0;
        check("scan_busy", {31'd0, busy}, 32'd1);
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) bc++;
            else break;
        end
        check("scan_busy_cycles", bc, 32'd8);
        wait_drain();
        check("busy_after_scan", {31'd0, busy}, 32'd0);
        check("count_after_20_wrapped", {28'd0, dec_count}, 32'd4);

        // Counter wrap: 11 more reaches all-ones, the next wraps to zero.
        for (int i = 0; i < 11; i++) send(3'(i % 8), 1'b1, onehot_tbl[i % 8]);
        wait_drain();
        check("count_all_ones", {28'd0, dec_count}, 32'd15);
        send(3'd7, 1'b1, 8'h80);
        wait_drain();
        check("count_wrap", {28'd0, dec_count}, 32'd0);

        // Reset mid-sweep with words buffered.
        out_ready = 1'b0;
        send(3'd2, 1'b1, 8'h04);
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_data",  {24'd0, out_data},  32'h0);
        check("async_rst_busy",  {31'd0, busy},      32'd0);
        check("async_rst_count", {28'd0, dec_count}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready",  {31'd0, in_ready},  32'd1);
        check("rel_out_valid", {31'd0, out_valid}, 32'd0);
        check("rel_count",     {28'd0, dec_count}, 32'd0);
        @(posedge clk); #1;
        send(3'd4, 1'b1, 8'h10);
        wait_drain();
        check("count_after_rst", {28'd0, dec_count}, 32'd1);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
